ir_fetch_seq: RTL and testbench
===============================

# ir_fetch_seq

Instruction-fetch sequencer driving the nibble-wide instruction register from the 4-bit instruction memory. On a fetch request it reads the four nibbles of one 16-bit instruction word in order, most significant first, and presents each nibble with its one-hot load enable, `ir_en`, to the instruction register. It handshakes each nibble read with the memory, reports completion, and supports abort and a memory-response watchdog.

## Interface
Parameters:
- `PC_W`, 13: instruction word address width, equal to the `imm_address` width.
- `WAIT_MAX`, 15: maximum cycles spent in WAIT per nibble before error; 0 disables the watchdog.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `fetch_req` in 1: start a fetch of word `pc`; sampled only in IDLE.
- `pc` in `PC_W`: word address, latched when `fetch_req` is accepted.
- `fetch_abort` in 1: cancel the fetch in progress.
- `mem_rd` out 1: one-cycle nibble read strobe.
- `mem_addr` out `PC_W`+2: nibble address `{pc_latched, idx[1:0]}`.
- `mem_valid` in 1: read data valid; any latency of 1 or more cycles after `mem_rd`.
- `mem_rdata` in 4: nibble read data.
- `ir_nibble` out 4: nibble to the instruction register `mem` input.
- `ir_en` out 4: one-hot load enable (`1000`, `0100`, `0010`, `0001` for idx 0 to 3); `0000` otherwise.
- `busy` out 1: high in every state except IDLE.
- `fetch_done` out 1: one-cycle pulse when the word is complete.
- `fetch_err` out 1: one-cycle pulse on watchdog expiry.

## Operation
- States: IDLE, REQ, WAIT, DONE. All outputs are registered.
- IDLE: on `fetch_req`, latch `pc`, set idx=0, go to REQ. `mem_valid` is ignored in IDLE.
- REQ: drive `mem_rd`=1 and `mem_addr`={pc_latched, idx} for exactly one cycle, clear the wait counter, go to WAIT.
- WAIT:
  - On `mem_valid`, next cycle `ir_nibble`=`mem_rdata` and `ir_en`=onehot(idx).
  - If idx=3, go to DONE; otherwise idx+1 and go to REQ.
  - Without `mem_valid`, the wait counter increments. When `WAIT_MAX`≠0 and the counter reaches `WAIT_MAX`, pulse `fetch_err` and go to IDLE; `ir_en` stays `0000`.
- DONE: `fetch_done`=1 for one cycle, coincident with `ir_en`=`0001`, then go to IDLE.
- `ir_en` is high for exactly one cycle per nibble. Between nibbles `ir_en`=`0000`, and `ir_nibble` holds its last value.
- `fetch_req` while `busy` is ignored and is not queued.
- `fetch_abort` in REQ, WAIT or DONE: next state is IDLE, and `ir_en`, `mem_rd`, `fetch_done` and `fetch_err` are 0 that cycle. A late `mem_valid` is then ignored in IDLE. Already-loaded IR nibbles are not undone.
- `fetch_abort` and `fetch_req` in the same IDLE cycle: the request wins, because abort has no effect in IDLE.
- `mem_valid` outside WAIT is ignored.
- idx is 2 bits, so the nibble address never carries into `pc`. `pc` all-ones is legal; the last nibble address is all-ones.

## Timing
- Reset: state IDLE, idx=0, and `mem_rd`, `mem_addr`, `ir_nibble`, `ir_en`, `busy`, `fetch_done`, `fetch_err` all 0.
- With 1-cycle memory latency and `fetch_req` at cycle 0:
  - `mem_rd` at cycles 1, 3, 5, 7.
  - `mem_valid` at cycles 2, 4, 6, 8.
  - `ir_en` = `1000`@3, `0100`@5, `0010`@7, `0001`@9.
  - `fetch_done`@9; `busy` cycles 1–9; IDLE at cycle 10.
- Memory latency L adds L−1 cycles per nibble.
- Throughput: a new `fetch_req` is accepted at the earliest in the cycle after `fetch_done`.
- Watchdog with `WAIT_MAX`=N and no `mem_valid`: `fetch_err` appears N cycles after the first WAIT cycle.
- Reset mid-fetch: outputs return to reset values on the next edge and any in-flight response is discarded.

## Structure
- Shared package `ir_fetch_pkg`:
  - state enum.
  - One-hot enable constants `IR_EN_HI`=`1000` down to `IR_EN_LO`=`0001`, also used by the IR-side bench.
  - `NIB_W`=4.
- One natural sub-module: `ir_fetch_wdog`, the wait counter with clear/enable/expired and a `WAIT_MAX` parameter.
- The rest is a single FSM with an idx counter.

## Test plan
- Word fetch, 1-cycle memory model holding `16'hA5C3` at `pc`=`13'h0004`:
  - `mem_addr` = `15'h0010`, `0011`, `0012`, `0013` in that order.
  - `ir_en`/`ir_nibble` = `1000`/A, `0100`/5, `0010`/C, `0001`/3.
  - `fetch_done`@9; an attached IR holds `16'hA5C3`.
- Variable latency (3, 1, 5, 2 cycles per nibble): correct nibble order, exactly four `ir_en` pulses, `fetch_done` coincident with the last pulse.
- `fetch_abort` in WAIT of idx 2, then `mem_valid` one cycle later: no `ir_en` `0010`, no `fetch_done`; IDLE next cycle; the next `fetch_req` restarts at idx 0.
- `WAIT_MAX`=4 and memory never responds: `fetch_err` pulses 4 cycles into WAIT, `busy` drops, `ir_en` stays `0000`.
- `fetch_req` asserted continuously, and reset asserted at cycle 5: only one fetch in flight at a time; after reset all outputs are 0 and the next fetch begins cleanly.
- `pc`=`13'h1FFF`: last nibble address is `15'h7FFF` with no wrap into `pc` bits.

Source files
------------

// File: rtl/ir_fetch_pkg.sv
// Shared types and constants for the nibble-wide instruction fetch path.
package ir_fetch_pkg;

  localparam int NIB_W = 4;

  localparam logic [3:0] IR_EN_HI = 4'b1000;
  localparam logic [3:0] IR_EN_MH = 4'b0100;
  localparam logic [3:0] IR_EN_ML = 4'b0010;
  localparam logic [3:0] IR_EN_LO = 4'b0001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // idx 0 is the most significant nibble of the instruction word.
  function automatic logic [3:0] ir_en_onehot(input logic [1:0] idx);
    case (idx)
      2'd0:    return IR_EN_HI;
      2'd1:    return IR_EN_MH;
      2'd2:    return IR_EN_ML;
      default: return IR_EN_LO;
    endcase
  endfunction

endpackage

// File: rtl/ir_fetch_wdog.sv
// Memory-response watchdog: counts WAIT cycles without data; WAIT_MAX=0 disables it.
module ir_fetch_wdog #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CNT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);
  localparam int unsigned LIMIT = (WAIT_MAX == 0) ? 0 : WAIT_MAX - 1;

  logic [CNT_W-1:0] cnt;

  // expired flags the last silent cycle, so the registered error lands WAIT_MAX cycles into WAIT.
  assign expired = (WAIT_MAX != 0) && (cnt == CNT_W'(LIMIT));

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ir_fetch_seq.sv
// Instruction-fetch sequencer: reads four nibbles of one word, MSB first, into the IR.
//
// state | meaning
// IDLE  | waiting for fetch_req; mem_valid ignored
// REQ   | one-cycle nibble read strobe for {pc_lat, idx}
// WAIT  | waiting for mem_valid, watchdog running
// DONE  | last nibble loaded, fetch_done pulse
module ir_fetch_seq
  import ir_fetch_pkg::*;
#(
  parameter int          PC_W     = 13,
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [PC_W-1:0]   pc,
  input  logic              fetch_abort,
  output logic              mem_rd,
  output logic [PC_W+1:0]   mem_addr,
  input  logic              mem_valid,
  input  logic [NIB_W-1:0]  mem_rdata,
  output logic [NIB_W-1:0]  ir_nibble,
  output logic [3:0]        ir_en,
  output logic              busy,
  output logic              fetch_done,
  output logic              fetch_err
);

  state_t          state, state_n;
  logic [1:0]      idx, idx_n;
  logic [PC_W-1:0] pc_lat, pc_lat_n;
  logic            wd_clr, wd_en, wd_expired;
  logic            nib_load, err_n;

  ir_fetch_wdog #(.WAIT_MAX(WAIT_MAX)) u_wdog (
    .clk     (clk),
    .reset   (reset),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

  always_comb begin
    state_n  = state;
    idx_n    = idx;
    pc_lat_n = pc_lat;
    wd_clr   = 1'b0;
    wd_en    = 1'b0;
    nib_load = 1'b0;
    err_n    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (fetch_req) begin
          pc_lat_n = pc;
          idx_n    = '0;
          state_n  = ST_REQ;
        end
      end
      ST_REQ: begin
        wd_clr  = 1'b1;
        state_n = fetch_abort ? ST_IDLE : ST_WAIT;
      end
      ST_WAIT: begin
        if (fetch_abort) begin
          state_n = ST_IDLE;
        end else if (mem_valid) begin
          nib_load = 1'b1;
          if (idx == 2'd3) begin
            state_n = ST_DONE;
          end else begin
            idx_n   = idx + 2'd1;
            state_n = ST_REQ;
          end
        end else if (wd_expired) begin
          err_n   = 1'b1;
          state_n = ST_IDLE;
        end else begin
          wd_en = 1'b1;
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next-state decision so they line up with the new state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      idx        <= '0;
      pc_lat     <= '0;
      mem_rd     <= 1'b0;
      mem_addr   <= '0;
      ir_nibble  <= '0;
      ir_en      <= '0;
      busy       <= 1'b0;
      fetch_done <= 1'b0;
      fetch_err  <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      pc_lat     <= pc_lat_n;
      mem_rd     <= (state_n == ST_REQ);
      if (state_n == ST_REQ) begin
        mem_addr <= {pc_lat_n, idx_n};
      end
      if (nib_load) begin
        ir_nibble <= mem_rdata;
      end
      ir_en      <= nib_load ? ir_en_onehot(idx) : 4'b0000;
      busy       <= (state_n != ST_IDLE);
      fetch_done <= (state_n == ST_DONE);
      fetch_err  <= err_n;
    end
  end

endmodule

// File: tb/tb_ir_fetch_seq.sv
// Self-checking bench for ir_fetch_seq with a word-level memory and IR model.
`define CHK(tag, obs, exp) begin checks++; assert ((obs) === (exp)) else begin errors++; $error("FAIL %s: observed %0h expected %0h", tag, (obs), (exp)); end end

module tb_ir_fetch_seq;

  localparam int PC_W = 13;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            fetch_req = 1'b0;
  logic            fetch_req2 = 1'b0;
  logic            fetch_abort = 1'b0;
  logic            mem_valid = 1'b0;
  logic [PC_W-1:0] pc = '0;
  logic [3:0]      mem_rdata = '0;

  logic            mem_rd, busy, fetch_done, fetch_err;
  logic [PC_W+1:0] mem_addr;
  logic [3:0]      ir_nibble, ir_en;

  logic            wd_mem_rd, wd_busy, wd_fetch_done, wd_fetch_err;
  logic [PC_W+1:0] wd_mem_addr;
  logic [3:0]      wd_ir_nibble, wd_ir_en;

  ir_fetch_seq #(.PC_W(PC_W), .WAIT_MAX(15)) dut (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .pc(pc), .fetch_abort(fetch_abort),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_valid(mem_valid), .mem_rdata(mem_rdata),
    .ir_nibble(ir_nibble), .ir_en(ir_en), .busy(busy), .fetch_done(fetch_done),
    .fetch_err(fetch_err)
  );

  ir_fetch_seq #(.PC_W(PC_W), .WAIT_MAX(4)) dut_wd (
    .clk(clk), .reset(reset), .fetch_req(fetch_req2), .pc(pc), .fetch_abort(fetch_abort),
    .mem_rd(wd_mem_rd), .mem_addr(wd_mem_addr), .mem_valid(mem_valid), .mem_rdata(mem_rdata),
    .ir_nibble(wd_ir_nibble), .ir_en(wd_ir_en), .busy(wd_busy), .fetch_done(wd_fetch_done),
    .fetch_err(wd_fetch_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int          lat [4];
  bit          abort_with_req = 1'b0;
  logic [14:0] q_addr [$];
  logic [3:0]  q_en [$];
  logic [3:0]  q_nib [$];
  int          done_cyc, n_done, n_err, busy_cnt, n_rd_total;
  logic        post_abort_busy;
  logic [26:0] rst_snap;
  logic [15:0] ir_reg;

  // Memory holds one word at wpc; any other address returns junk.
  function automatic logic [3:0] nib_of(logic [14:0] a, logic [12:0] wpc, logic [15:0] w);
    logic [12:0] wa;
    int          sel;
    wa  = a[14:2];
    sel = int'(a[1:0]);
    if (wa != wpc) return 4'($urandom);
    return 4'(w >> (4 * (3 - sel)));
  endfunction

  task automatic run_fetch(input logic [12:0] fpc, input logic [15:0] word,
                           input int abort_idx, input int reset_at, input int limit);
    int         c, vcyc, n_rd, abort_cyc;
    logic [3:0] vdata;
    bit         hold;
    q_addr.delete(); q_en.delete(); q_nib.delete();
    done_cyc = -1; n_done = 0; n_err = 0; busy_cnt = 0; ir_reg = '0;
    post_abort_busy = 1'bx; rst_snap = 'x;
    c = 0; vcyc = -1; n_rd = 0; abort_cyc = -1; vdata = '0;
    hold = (reset_at >= 0);
    pc = fpc; fetch_req = 1'b1; fetch_abort = abort_with_req;
    mem_valid = 1'b0; mem_rdata = 4'($urandom);
    while (c < limit) begin
      @(posedge clk); #1; c++;
      if (mem_rd) begin
        q_addr.push_back(mem_addr);
        vcyc  = c + lat[n_rd & 3];
        vdata = nib_of(mem_addr, fpc, word);
        n_rd++;
        if (n_rd == abort_idx + 1) abort_cyc = c + 1;
      end
      if (ir_en != 4'b0000) begin
        q_en.push_back(ir_en);
        q_nib.push_back(ir_nibble);
        for (int k = 0; k < 4; k++)
          if (ir_en[3-k]) ir_reg[15-4*k -: 4] = ir_nibble;
      end
      if (fetch_done) begin n_done++; done_cyc = c; end
      if (fetch_err) n_err++;
      if (busy) busy_cnt++;
      if (abort_cyc >= 0 && c == abort_cyc + 1) post_abort_busy = busy;
      if (c == reset_at + 1) begin
        rst_snap = {mem_rd, mem_addr, ir_nibble, ir_en, busy, fetch_done, fetch_err};
        hold = 1'b0;
      end
      fetch_req   = hold;
      reset       = (c == reset_at);
      fetch_abort = (c == abort_cyc);
      mem_valid   = (c == vcyc);
      mem_rdata   = mem_valid ? vdata : 4'($urandom);
      pc          = 13'($urandom);
    end
    n_rd_total = n_rd;
    fetch_req = 1'b0; fetch_abort = 1'b0; mem_valid = 1'b0; reset = 1'b0;
  endtask

  task automatic check_normal(input logic [12:0] fpc, input logic [15:0] word);
    int          exp_done;
    logic [14:0] exp_a;
    exp_done = 1;
    for (int i = 0; i < 4; i++) exp_done += lat[i] + 1;
    `CHK("addr_count", q_addr.size(), 4)
    `CHK("en_count", q_en.size(), 4)
    for (int i = 0; i < 4; i++) begin
      exp_a = {fpc, 2'(i)};
      if (i < q_addr.size()) `CHK("mem_addr", q_addr[i], exp_a)
      if (i < q_en.size()) begin
        `CHK("ir_en", q_en[i], 4'(8 >> i))
        `CHK("ir_nibble", q_nib[i], 4'(word >> (12 - 4 * i)))
      end
    end
    `CHK("done_cycle", done_cyc, exp_done)
    `CHK("done_count", n_done, 1)
    `CHK("err_count", n_err, 0)
    `CHK("busy_cycles", busy_cnt, exp_done)
    `CHK("ir_word", ir_reg, word)
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [12:0] rpc;
    logic [15:0] rword;
    int          c, err_cyc, n_err2, n_rd2, n_done2;
    logic        busy_at_err, busy5, en2_any;
    logic [14:0] rd2_addr;

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    `CHK("rst_mem_rd", mem_rd, 1'b0)
    `CHK("rst_mem_addr", mem_addr, 15'h0)
    `CHK("rst_ir_nibble", ir_nibble, 4'h0)
    `CHK("rst_ir_en", ir_en, 4'h0)
    `CHK("rst_busy", busy, 1'b0)
    `CHK("rst_fetch_done", fetch_done, 1'b0)
    `CHK("rst_fetch_err", fetch_err, 1'b0)
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    lat = '{1, 1, 1, 1};
    run_fetch(13'h0004, 16'hA5C3, -1, -1, 14);
    check_normal(13'h0004, 16'hA5C3);

    lat = '{3, 1, 5, 2};
    rword = 16'($urandom);
    rpc   = 13'($urandom);
    run_fetch(rpc, rword, -1, -1, 22);
    check_normal(rpc, rword);

    for (int n = 0; n < 4; n++) begin
      int lim;
      lim = 4;
      for (int i = 0; i < 4; i++) begin
        lat[i] = int'($urandom_range(1, 6));
        lim += lat[i] + 1;
      end
      rword = 16'($urandom);
      rpc   = 13'($urandom);
      abort_with_req = (n == 1);
      run_fetch(rpc, rword, -1, -1, lim);
      abort_with_req = 1'b0;
      check_normal(rpc, rword);
    end

    lat = '{1, 1, 1, 1};
    rword = 16'($urandom);
    run_fetch(13'h1FFF, rword, -1, -1, 14);
    check_normal(13'h1FFF, rword);
    if (q_addr.size() == 4) `CHK("last_addr_no_wrap", q_addr[3], 15'h7FFF)

    lat = '{1, 1, 2, 1};
    rword = 16'($urandom);
    run_fetch(13'h0123, rword, 2, -1, 12);
    `CHK("abort_rd_count", n_rd_total, 3)
    `CHK("abort_en_count", q_en.size(), 2)
    `CHK("abort_done_count", n_done, 0)
    `CHK("abort_idle_next", post_abort_busy, 1'b0)
    lat = '{2, 1, 1, 3};
    rword = 16'($urandom);
    run_fetch(13'h0ABC, rword, -1, -1, 16);
    check_normal(13'h0ABC, rword);

    lat = '{1, 1, 1, 1};
    rword = 16'($urandom);
    run_fetch(13'h0777, rword, -1, 5, 10);
    `CHK("rstmid_rd_count", n_rd_total, 3)
    if (q_addr.size() == 3) `CHK("rstmid_third_addr", q_addr[2], 15'h1DDE)
    `CHK("rstmid_en_count", q_en.size(), 2)
    `CHK("rstmid_done_count", n_done, 0)
    `CHK("rstmid_busy_cycles", busy_cnt, 5)
    `CHK("rstmid_outputs", rst_snap, 27'h0)
    lat = '{1, 2, 1, 1};
    rword = 16'($urandom);
    run_fetch(13'h0042, rword, -1, -1, 15);
    check_normal(13'h0042, rword);

    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    pc = 13'h0150; fetch_req2 = 1'b1; mem_valid = 1'b0;
    c = 0; err_cyc = -1; n_err2 = 0; n_rd2 = 0; n_done2 = 0;
    busy_at_err = 1'bx; busy5 = 1'bx; en2_any = 1'b0; rd2_addr = 'x;
    while (c < 12) begin
      @(posedge clk); #1; c++;
      fetch_req2 = 1'b0;
      if (wd_fetch_err) begin n_err2++; err_cyc = c; busy_at_err = wd_busy; end
      if (wd_ir_en != 4'b0000) en2_any = 1'b1;
      if (wd_mem_rd) begin n_rd2++; rd2_addr = wd_mem_addr; end
      if (wd_fetch_done) n_done2++;
      if (c == 5) busy5 = wd_busy;
    end
    `CHK("wd_err_cycle", err_cyc, 6)
    `CHK("wd_err_count", n_err2, 1)
    `CHK("wd_busy_before", busy5, 1'b1)
    `CHK("wd_busy_at_err", busy_at_err, 1'b0)
    `CHK("wd_ir_en_quiet", en2_any, 1'b0)
    `CHK("wd_rd_count", n_rd2, 1)
    `CHK("wd_rd_addr", rd2_addr, 15'h0540)
    `CHK("wd_done_count", n_done2, 0)
    `CHK("wd_ir_nibble", wd_ir_nibble, 4'h0)

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
